// File: rtl/arbiter_requester_if.sv
// Request/grant bundle between client-side front end and the arbiter.
// master drives push/grant, slave is the requester front end.
interface arbiter_requester_if #(
    parameter int N  = 4,
    parameter int CW = 8
);
    logic [N-1:0]  push;
    logic [N-1:0]  grant;
    logic [N-1:0]  request;
    logic [N-1:0]  done;
    logic [N-1:0]  starve;
    logic [N-1:0]  overrun;
    logic [CW-1:0] wait_max;
    logic          error;

    modport master (
        output push, grant,
        input  request, done, starve, overrun, wait_max, error
    );

    modport slave (
        input  push, grant,
        output request, done, starve, overrun, wait_max, error
    );
endinterface

// File: rtl/arbiter_requester.sv
// Requester front end: holds per-channel requests until granted and
// tracks wait time, starvation, overrun and grant-protocol errors.
module arbiter_requester #(
    parameter int N       = 4,
    parameter int CW      = 8,
    parameter int MAXWAIT = 16
) (
    input  logic              clk,
    input  logic              nreset,
    arbiter_requester_if.slave bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_SAT   = '1;
    localparam logic [CW-1:0] STARVE_AT = CW'(MAXWAIT);

    state_t        r_state     [N];
    state_t        w_state_nxt [N];
    logic [CW-1:0] r_cnt       [N];
    logic [CW-1:0] w_cnt_nxt   [N];

    logic [N-1:0]  r_done, w_done_nxt;
    logic [N-1:0]  r_starve, w_starve_nxt;
    logic [N-1:0]  r_overrun, w_overrun_nxt;
    logic [CW-1:0] r_wait_max, w_wait_max_nxt;
    logic          r_error, w_error_nxt;

    logic [N-1:0]  w_req;
    logic          w_multi;
    logic          w_stray;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_req[i] = (r_state[i] == ST_REQ);
        end
    end

    assign w_multi = ($countones(bus.grant) > 1);
    assign w_stray = |(bus.grant & ~w_req);

    always_comb begin
        w_done_nxt     = '0;
        w_starve_nxt   = r_starve;
        w_overrun_nxt  = r_overrun;
        w_wait_max_nxt = r_wait_max;
        w_error_nxt    = r_error | w_multi | w_stray;
        for (int i = 0; i < N; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            unique case (r_state[i])
                ST_IDLE: begin
                    // stray grant bits on idle channels change nothing
                    if (bus.push[i]) begin
                        w_state_nxt[i] = ST_REQ;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                ST_REQ: begin
                    if (bus.grant[i]) begin
                        w_done_nxt[i]   = 1'b1;
                        w_starve_nxt[i] = 1'b0;
                        if (r_cnt[i] > w_wait_max_nxt)
                            w_wait_max_nxt = r_cnt[i];
                        w_cnt_nxt[i] = '0;
                        if (!bus.push[i])
                            w_state_nxt[i] = ST_IDLE;
                    end else begin
                        if (r_cnt[i] != CNT_SAT)
                            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                        if (w_cnt_nxt[i] == STARVE_AT)
                            w_starve_nxt[i] = 1'b1;
                        if (bus.push[i])
                            w_overrun_nxt[i] = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
            r_done     <= '0;
            r_starve   <= '0;
            r_overrun  <= '0;
            r_wait_max <= '0;
            r_error    <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_done     <= w_done_nxt;
            r_starve   <= w_starve_nxt;
            r_overrun  <= w_overrun_nxt;
            r_wait_max <= w_wait_max_nxt;
            r_error    <= w_error_nxt;
        end
    end

    assign bus.request  = w_req;
    assign bus.done     = r_done;
    assign bus.starve   = r_starve;
    assign bus.overrun  = r_overrun;
    assign bus.wait_max = r_wait_max;
    assign bus.error    = r_error;
endmodule

// File: tb/tb_arbiter_requester.sv
// Closed-loop bench for arbiter_requester with a fixed-priority arbiter,
// a behavioural reference model and a scoreboard queue.
module tb_arbiter_requester;
    localparam int N  = 4;
    localparam int CW = 8;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic direct_mode = 1'b0;
    logic [N-1:0] direct_grant = '0;
    logic [N-1:0] arb_grant;

    arbiter_requester_if #(.N(N), .CW(CW)) bus ();

    arbiter_requester #(.N(N), .CW(CW), .MAXWAIT(MW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // fixed priority, bit 0 highest
    assign arb_grant = bus.request & (~bus.request + 1'b1);
    assign bus.grant = direct_mode ? direct_grant : arb_grant;

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  done;
        logic [N-1:0]  starve;
        logic [N-1:0]  overrun;
        logic [CW-1:0] wmax;
        logic          err;
    } exp_t;

    exp_t sbq[$];
    int n_chk = 0;
    int n_fail = 0;

    // reference model: pending flag plus integer wait per channel
    bit m_pend [N];
    int m_wait [N];
    bit m_starve [N];
    bit m_over [N];
    int m_wmax;
    bit m_err;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_wait[i] = 0;
            m_starve[i] = 0; m_over[i] = 0;
        end
        m_wmax = 0;
        m_err = 0;
        forever begin
            exp_t e;
            logic [N-1:0] g;
            logic [N-1:0] p;
            @(posedge clk);
            g = bus.grant;
            p = bus.push;
            e.done = '0;
            if (!nreset) begin
                for (int i = 0; i < N; i++) begin
                    m_pend[i] = 0; m_wait[i] = 0;
                    m_starve[i] = 0; m_over[i] = 0;
                end
                m_wmax = 0;
                m_err = 0;
            end else begin
                int ones;
                ones = 0;
                for (int i = 0; i < N; i++) begin
                    if (g[i]) ones++;
                    if (g[i] && !m_pend[i]) m_err = 1;
                end
                if (ones > 1) m_err = 1;
                for (int i = 0; i < N; i++) begin
                    if (m_pend[i] && g[i]) begin
                        e.done[i] = 1'b1;
                        if (m_wait[i] > m_wmax) m_wmax = m_wait[i];
                        m_starve[i] = 0;
                        m_wait[i] = 0;
                        m_pend[i] = p[i];
                    end else if (m_pend[i]) begin
                        m_wait[i] = (m_wait[i] >= 255) ? 255 : m_wait[i] + 1;
                        if (m_wait[i] == MW) m_starve[i] = 1;
                        if (p[i]) m_over[i] = 1;
                    end else if (p[i]) begin
                        m_pend[i] = 1;
                        m_wait[i] = 0;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                e.req[i] = m_pend[i];
                e.starve[i] = m_starve[i];
                e.overrun[i] = m_over[i];
            end
            e.wmax = CW'(m_wmax);
            e.err = m_err;
            sbq.push_back(e);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %h expected %h",
                         nm, $time, act, exp);
        end
    endtask

    // monitor: outputs are registered, compare away from the edge
    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("request",  8'(bus.request),  8'(e.req));
                chk("done",     8'(bus.done),     8'(e.done));
                chk("starve",   8'(bus.starve),   8'(e.starve));
                chk("overrun",  8'(bus.overrun),  8'(e.overrun));
                chk("wait_max", bus.wait_max,     e.wmax);
                chk("error",    8'(bus.error),    8'(e.err));
            end
        end
    end

    task automatic tick(input logic [N-1:0] p);
        @(negedge clk);
        bus.push = p;
    endtask

    task automatic idle(input int n);
        repeat (n) tick('0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        nreset = 1'b0;
        bus.push = '0;
        repeat (n) @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        bus.push = '0;
        do_reset(3);
        idle(10);

        tick(4'b0100);
        idle(5);

        tick(4'b1111);
        idle(8);

        // ch0 re-armed every cycle starves ch1 until saturation
        tick(4'b0011);
        repeat (270) tick(4'b0001);
        idle(6);

        // ch2 pushed twice while ch0 keeps the grant
        tick(4'b0101);
        tick(4'b0001);
        tick(4'b0101);
        tick(4'b0001);
        idle(6);

        // bench-driven grant: multi-hot, stray bit, reset mid-wait
        do_reset(1);
        @(negedge clk);
        direct_mode = 1'b1;
        direct_grant = '0;
        tick(4'b0011);
        idle(2);
        direct_grant = 4'b0011;
        @(negedge clk);
        direct_grant = 4'b1000;
        @(negedge clk);
        direct_grant = 4'b0000;
        tick(4'b0100);
        idle(3);
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        idle(3);

        // random closed loop
        direct_mode = 1'b0;
        do_reset(1);
        repeat (600) begin
            logic [N-1:0] p;
            for (int i = 0; i < N; i++)
                p[i] = ($urandom_range(0, 3) == 0);
            tick(p);
        end
        idle(10);

        // random direct grants with occasional reset
        direct_mode = 1'b1;
        do_reset(1);
        repeat (300) begin
            logic [N-1:0] p;
            logic [N-1:0] g;
            for (int i = 0; i < N; i++)
                p[i] = ($urandom_range(0, 2) == 0);
            g = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0)
                g = g & (~g + 1'b1);
            @(negedge clk);
            bus.push = p;
            direct_grant = g;
            nreset = ($urandom_range(0, 60) != 0);
        end
        @(negedge clk);
        nreset = 1'b1;
        direct_grant = '0;
        idle(5);

        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/arbiter_requester.md
# arbiter_requester

Requester-side front end for the combinational priority arbiter. Converts per-channel request pulses into held, registered `request` lines and retires each one when the arbiter's `grant` answers it. Tracks per-channel wait time, starvation, overrun and protocol errors. Sits between N client blocks and the arbiter, closing the request/grant loop.

## Interface
- `N`, 4: number of channels (≥2)
- `CW`, 8: width of wait counters and `wait_max`
- `MAXWAIT`, 16: wait cycles at which a channel is flagged starved (1 ≤ MAXWAIT ≤ 2^CW−1)

- `clk` in 1: clock, all state updates on rising edge
- `nreset` in 1: synchronous, active-low reset
- `push` in N: per-channel pulse; raises that channel's request
- `grant` in N: arbiter grant, expected one-hot or zero, combinational from `request`
- `request` out N: registered held request to arbiter
- `done` out N: one-cycle pulse, channel's request retired
- `starve` out N: sticky per channel, waited ≥ MAXWAIT cycles
- `overrun` out N: sticky per channel, push dropped while pending
- `wait_max` out CW: largest wait observed at any retirement, saturating
- `error` out 1: sticky grant-protocol violation

## Operation
- Reset (`nreset`=0 at an edge): every output and internal register to 0, including sticky flags. This holds mid-operation; pending requests are discarded.
- Per channel i, two-state FSM:
  - IDLE (`request[i]`=0): `push[i]` → REQ, `cnt[i]`←0.
  - REQ (`request[i]`=1):
    - `grant[i]`=1 → `done[i]`←1 and retire. With no `push[i]` the channel goes to IDLE. With `push[i]` in the same cycle it stays in REQ (re-arm) and `cnt[i]`←0.
    - `grant[i]`=0 → `cnt[i]`←min(`cnt[i]`+1, 2^CW−1). If `push[i]`=1, the push is dropped and `overrun[i]`←1.
- Starvation: `starve[i]`←1 on the edge where `cnt[i]` becomes MAXWAIT. It clears on the edge where channel i is granted, unless set by the same edge, which cannot happen because the grant resets the count.
- `wait_max`: on a retire of channel i, `wait_max`←max(`wait_max`, `cnt[i]`). With one-hot grant, at most one channel retires per cycle. It is only cleared by reset.
- `error`←1 when either condition holds:
  - `grant` has more than one bit set, or
  - `grant[i]`=1 while `request[i]`=0.
  - Erroneous grant bits on idle channels are otherwise ignored (no state change).
  - If grant is multi-hot, each set bit whose channel is in REQ still retires. `wait_max` takes the max over all retiring channels.
- `grant`=0 is legal (arbiter idle or no requests).

## Timing
- `push[i]` sampled at edge k → `request[i]`=1 from edge k; first possible grant is in cycle k→k+1.
- Grant sampled at edge t → `request[i]` falls after edge t (unless re-armed) and `done[i]`=1 for exactly the cycle t→t+1.
- Latency from push to done with an immediate grant: 2 edges.
- Wait count equals the number of edges at which the request was held without a grant. An immediately granted request retires with wait 0.
- `starve`, `overrun`, `error` and `wait_max` update at the same edge as their triggering sample. All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
The bench closes the loop with the fixed-priority arbiter (bit 0 highest), N=4, CW=8, MAXWAIT=4, unless noted.
- Reset held 3 cycles, then released with no push → `request`, `done`, `starve`, `overrun`, `error`=0, `wait_max`=0 for 10 cycles.
- Push `push`=0100 for one cycle → `request`=0100 next cycle, `done`=0100 the following cycle, then `request`=0000; `wait_max`=0.
- Push `push`=1111 for one cycle → `done` pulses 0001, 0010, 0100, 1000 on consecutive cycles; `wait_max`=3; no `starve` (3 < 4).
- Re-push ch0 every cycle and push ch1 once → ch0 re-arms each grant. `starve[1]`=1 exactly 4 edges after `request[1]` rose, and `cnt[1]` saturates at 255. Stop ch0 → ch1 granted, `starve[1]` clears, `wait_max`=255.
- Push ch2 twice while ch0 holds grant → `overrun[2]`=1 sticky. Ch2 still retires once (single `done[2]` pulse).
- Bench drives `grant` directly:
  - 0011 with ch0 and ch1 pending → `error`=1, both retire.
  - Then 1000 with ch3 idle → `error` stays 1 and ch3 state is unchanged.
  - Then assert `nreset`=0 mid-wait → all outputs 0 at the next edge.
